mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter with a registered command stage.
// Read responses are routed back by a tag pipe that matches memory latency.
module mem_arbiter #(
    parameter int RDLAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [31:0] adr0,
    input  logic [31:0] adr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    input  logic        freeze,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_adr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    // last_q doubles as the owner of the command currently in m_* regs
    logic             last_q, last_d;
    logic             m_en_q, m_en_d;
    logic             m_we_q, m_we_d;
    logic [31:0]      m_adr_q, m_adr_d;
    logic [31:0]      m_wdata_q, m_wdata_d;
    logic [RDLAT-1:0] tag_v_q, tag_v_d;
    logic [RDLAT-1:0] tag_o_q, tag_o_d;
    logic             gnt0_c, gnt1_c;

    // Round-robin pick: on contention the port not granted last wins
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!rst && !freeze) begin
            if (req0 && req1) begin
                if (last_q) gnt0_c = 1'b1;
                else        gnt1_c = 1'b1;
            end else if (req0) begin
                gnt0_c = 1'b1;
            end else if (req1) begin
                gnt1_c = 1'b1;
            end
        end
    end

    // Next command register contents and pointer update
    always_comb begin
        last_d    = last_q;
        m_en_d    = 1'b0;
        m_we_d    = 1'b0;
        m_adr_d   = m_adr_q;
        m_wdata_d = m_wdata_q;
        if (gnt0_c) begin
            last_d    = 1'b0;
            m_en_d    = 1'b1;
            m_we_d    = we0;
            m_adr_d   = adr0;
            m_wdata_d = wdata0;
        end else if (gnt1_c) begin
            last_d    = 1'b1;
            m_en_d    = 1'b1;
            m_we_d    = we1;
            m_adr_d   = adr1;
            m_wdata_d = wdata1;
        end
    end

    // Tag pipe: a read enters when its command is on the memory bus
    always_comb begin
        tag_v_d    = '0;
        tag_o_d    = '0;
        tag_v_d[0] = m_en_q && !m_we_q;
        tag_o_d[0] = last_q;
        for (int i = 1; i < RDLAT; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_o_d[i] = tag_o_q[i-1];
        end
    end

    // State registers; reset drops in-flight reads and favours port 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q    <= 1'b1;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_adr_q   <= '0;
            m_wdata_q <= '0;
            tag_v_q   <= '0;
            tag_o_q   <= '0;
        end else begin
            last_q    <= last_d;
            m_en_q    <= m_en_d;
            m_we_q    <= m_we_d;
            m_adr_q   <= m_adr_d;
            m_wdata_q <= m_wdata_d;
            tag_v_q   <= tag_v_d;
            tag_o_q   <= tag_o_d;
        end
    end

    assign gnt0    = gnt0_c;
    assign gnt1    = gnt1_c;
    assign m_en    = m_en_q;
    assign m_we    = m_we_q;
    assign m_adr   = m_adr_q;
    assign m_wdata = m_wdata_q;
    assign rvalid0 = tag_v_q[RDLAT-1] && !tag_o_q[RDLAT-1];
    assign rvalid1 = tag_v_q[RDLAT-1] &&  tag_o_q[RDLAT-1];
    assign rdata0  = m_rdata;
    assign rdata1  = m_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at RDLAT=1 (a)
// and one at RDLAT=3 (b) driven with identical stimulus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, freeze;
    logic        req0, req1, we0, we1;
    logic [31:0] adr0, adr1, wdata0, wdata1, m_rdata;

    logic        gnt0_a, gnt1_a, rvalid0_a, rvalid1_a;
    logic [31:0] rdata0_a, rdata1_a;
    logic        m_en_a, m_we_a;
    logic [31:0] m_adr_a, m_wdata_a;

    logic        gnt0_b, gnt1_b, rvalid0_b, rvalid1_b;
    logic [31:0] rdata0_b, rdata1_b;
    logic        m_en_b, m_we_b;
    logic [31:0] m_adr_b, m_wdata_b;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.RDLAT(1)) dut_a (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_a), .gnt1(gnt1_a),
        .rvalid0(rvalid0_a), .rvalid1(rvalid1_a),
        .rdata0(rdata0_a), .rdata1(rdata1_a),
        .freeze(freeze),
        .m_en(m_en_a), .m_we(m_we_a), .m_adr(m_adr_a), .m_wdata(m_wdata_a),
        .m_rdata(m_rdata)
    );

    mem_arbiter #(.RDLAT(3)) dut_b (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0_b), .gnt1(gnt1_b),
        .rvalid0(rvalid0_b), .rvalid1(rvalid1_b),
        .rdata0(rdata0_b), .rdata1(rdata1_b),
        .freeze(freeze),
        .m_en(m_en_b), .m_we(m_we_b), .m_adr(m_adr_b), .m_wdata(m_wdata_b),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start a new cycle: inputs change at the falling edge, settle 1ns
    task automatic drive(input logic rs, input logic fz,
                         input logic r0, input logic w0,
                         input logic [31:0] a0,
                         input logic r1, input logic w1,
                         input logic [31:0] a1);
        @(negedge clk);
        rst = rs; freeze = fz;
        req0 = r0; we0 = w0; adr0 = a0;
        req1 = r1; we1 = w1; adr1 = a1;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        adr0 = '0; adr1 = '0;
        wdata0 = 32'hA5A5_0000; wdata1 = 32'h5A5A_0000;
        m_rdata = '0;

        // Reset holds everything quiet even with requests pending
        drive(1, 0, 1, 0, 32'h100, 1, 0, 32'h200);
        drive(1, 0, 1, 0, 32'h100, 1, 0, 32'h200);
        chk("rst_gnt0", gnt0_a, 0);
        chk("rst_gnt1", gnt1_a, 0);
        chk("rst_m_en", m_en_a, 0);
        chk("rst_m_we", m_we_a, 0);
        chk("rst_m_adr", m_adr_a, 0);
        chk("rst_m_wdata", m_wdata_a, 0);
        chk("rst_rvalid0", rvalid0_a, 0);
        chk("rst_rvalid1", rvalid1_b, 0);

        // Single read on port 0, first cycle after reset
        m_rdata = 32'h1234_5678;
        drive(0, 0, 1, 0, 32'h100, 0, 0, 0);
        chk("a_gnt0", gnt0_a, 1);
        chk("a_gnt1", gnt1_a, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("a_m_en", m_en_a, 1);
        chk("a_m_we", m_we_a, 0);
        chk("a_m_adr", m_adr_a, 32'h100);
        chk("a_rv0_early", rvalid0_a, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("a_rv0", rvalid0_a, 1);
        chk("a_rdata0", rdata0_a, 32'h1234_5678);
        chk("a_rv1", rvalid1_a, 0);
        chk("a_m_en_idle", m_en_a, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("a_rv0_once", rvalid0_a, 0);
        idle(4);

        // Both ports held: alternate 0,1,0,1,0,1 at full throughput
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            drive(0, 0, k < 6, 0, 32'h10, k < 6, 0, 32'h20);
            chk($sformatf("b_gnt0_%0d", k), gnt0_a, (k < 6) && (k % 2 == 0));
            chk($sformatf("b_gnt1_%0d", k), gnt1_a, (k < 6) && (k % 2 == 1));
            chk($sformatf("b_m_en_%0d", k), m_en_a, (k >= 1) && (k <= 6));
            chk($sformatf("b_m_adr_%0d", k), m_adr_a,
                (k == 0) ? 32'h0 : (k >= 7) ? 32'h20 :
                ((k - 1) % 2 == 0) ? 32'h10 : 32'h20);
            chk($sformatf("b_rv0_%0d", k), rvalid0_a,
                (k >= 2) && ((k - 2) % 2 == 0));
            chk($sformatf("b_rv1_%0d", k), rvalid1_a,
                (k >= 2) && ((k - 2) % 2 == 1));
        end
        idle(4);

        // Write on port 1 produces no read response
        wdata1 = 32'hDEAD_BEEF;
        drive(0, 0, 0, 0, 0, 1, 1, 32'h40);
        chk("c_gnt1", gnt1_a, 1);
        chk("c_gnt0", gnt0_a, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("c_m_en", m_en_a, 1);
        chk("c_m_we", m_we_a, 1);
        chk("c_m_adr", m_adr_a, 32'h40);
        chk("c_m_wdata", m_wdata_a, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) drive(0, 0, 0, 0, 0, 0, 0, 0);
            chk($sformatf("c_rv1a_%0d", k), rvalid1_a, 0);
            chk($sformatf("c_rv1b_%0d", k), rvalid1_b, 0);
        end
        chk("c_m_we_idle", m_we_a, 0);
        idle(2);

        // Reads 0,1,0 back to back; ordered returns at both latencies
        m_rdata = 32'hCAFE_F00D;
        for (int t = 0; t < 8; t++) begin
            drive(0, 0, (t == 0) || (t == 2), 0, 32'h300 + 4 * t,
                  t == 1, 0, 32'h304);
            chk($sformatf("d_gnt0_%0d", t), gnt0_a, (t == 0) || (t == 2));
            chk($sformatf("d_gnt1_%0d", t), gnt1_a, t == 1);
            chk($sformatf("d_rv0a_%0d", t), rvalid0_a, (t == 2) || (t == 4));
            chk($sformatf("d_rv1a_%0d", t), rvalid1_a, t == 3);
            chk($sformatf("d_rv0b_%0d", t), rvalid0_b, (t == 4) || (t == 6));
            chk($sformatf("d_rv1b_%0d", t), rvalid1_b, t == 5);
            if (t == 4) chk("d_rdata0b", rdata0_b, 32'hCAFE_F00D);
        end
        idle(2);

        // Freeze blocks grants but the in-flight read still returns
        drive(0, 0, 1, 0, 32'h400, 0, 0, 0);
        chk("e_gnt0_pre", gnt0_a, 1);
        for (int t = 1; t <= 3; t++) begin
            drive(0, 1, 1, 0, 32'h400, 0, 0, 0);
            chk($sformatf("e_gnt0_%0d", t), gnt0_a, 0);
            chk($sformatf("e_gnt1_%0d", t), gnt1_a, 0);
            chk($sformatf("e_m_en_%0d", t), m_en_a, t == 1);
            chk($sformatf("e_rv0_%0d", t), rvalid0_a, t == 2);
        end
        drive(0, 0, 1, 0, 32'h404, 0, 0, 0);
        chk("e_gnt0_post", gnt0_a, 1);
        chk("e_m_en_post", m_en_a, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("e_m_adr", m_adr_a, 32'h404);
        idle(4);

        // A write from the same port does not cancel its pending read
        drive(0, 0, 1, 0, 32'h500, 0, 0, 0);
        drive(0, 0, 1, 1, 32'h504, 0, 0, 0);
        chk("g_gnt0_wr", gnt0_a, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("g_rv0a", rvalid0_a, 1);
        chk("g_m_we", m_we_a, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("g_rv0a_once", rvalid0_a, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("g_rv0b", rvalid0_b, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("g_rv0b_once", rvalid0_b, 0);
        idle(2);

        // Reset right after a port-0 read grant discards the read
        drive(0, 0, 1, 0, 32'h600, 0, 0, 0);
        chk("f_gnt0_pre", gnt0_a, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        chk("f_m_en_rst", m_en_a, 0);
        chk("f_rv0_rst", rvalid0_a, 0);
        drive(0, 0, 1, 1, 32'h610, 1, 1, 32'h620);
        chk("f_gnt0", gnt0_a, 1);
        chk("f_gnt1", gnt1_a, 0);
        chk("f_rv0a_t2", rvalid0_a, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("f_m_adr", m_adr_a, 32'h610);
        chk("f_rv0a_t3", rvalid0_a, 0);
        chk("f_rv0b_t3", rvalid0_b, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("f_rv0b_t4", rvalid0_b, 0);
        chk("f_rv1b_t4", rvalid1_b, 0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
